cdm_mul_pipe: RTL and testbench
===============================

// Module: cdm_mul_pipe
// PURPOSE
//   Parametrised, pipelined carry-disregard approximate multiplier: W x W -> 2W.
//   Splits operands into four H=W/2 quadrant products, then merges them with
//   H-bit segment adders whose inter-segment carries are dropped (approx mode)
//   or propagated (exact mode, selected per transaction). Valid/ready streaming,
//   one result per cycle; successor to the fixed 16-bit combinational cdm16 multiplier.
// PARAMETERS
//   W        16  operand width; even, >= 4; H = W/2
//   LL_TRUNC 2   approx mode only: LSBs of A[H-1:0], B[H-1:0] cleared before LL product; 0..H
//   TAG_W    4   sideband tag width carried alongside each operation (>= 1)
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      block can accept a beat this cycle
//   in_a       in   W      multiplicand
//   in_b       in   W      multiplier
//   in_mode    in   1      0 = approximate (carry-disregard), 1 = exact
//   in_tag     in   TAG_W  returned unchanged with the result
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_r      out  2W     product
//   out_tag    out  TAG_W  tag of this result
// BEHAVIOUR
//   - Reset: out_valid=0, out_r=0, out_tag=0, all stage valids 0; in_ready=1 first cycle after rst.
//   - 3 register stages: S1 operands/mode/tag; S2 LL,HL,LH,HH (2H bits each); S3 merged result.
//   - Handshake: beat transfers when valid&&ready. ready_k = !valid_k || ready_(k+1);
//     ready_(4) = out_ready; in_ready = ready_1. Latency 3 cycles accept->out_valid with no
//     stall; full throughput 1/cycle; max 3 beats in flight; strict in-order.
//   - out_valid high holds out_r/out_tag stable until out_ready; no drop, no duplicate.
//   - Quadrants: LL=Alo*Blo, HL=Ahi*Blo, LH=Alo*Bhi, HH=Ahi*Bhi (Alo=A[H-1:0], Ahi=A[W-1:H]).
//     Approx mode: LL uses (Alo & ~((1<<LL_TRUNC)-1)) * (Blo & same mask).
//   - Approx merge, each segment H bits, sums taken mod 2^H (carries out discarded):
//     R[H-1:0]=LL.lo; R[2H-1:H]=LL.hi+HL.lo+LH.lo; R[3H-1:2H]=HL.hi+LH.hi+HH.lo; R[4H-1:3H]=HH.hi.
//   - Exact mode: out_r = in_a*in_b exactly (full carry propagation, LL not truncated).
//   - Mode is latched per beat in S1; mixing modes back-to-back is legal.
//   - rst mid-operation: all in-flight beats discarded, no result emitted for them.
//   - in_valid/in_a etc. ignored while in_ready=0; no X may propagate from idle inputs to out_r
//     while out_valid=1.
// CONFIGURATION
//   CDM_ERR_MON_EN defined: adds ports
//     err_mag   out 2W  |exact - delivered| for the beat currently on out_r (0 in exact mode)
//     err_count out 16  saturating (stops at 0xFFFF) count of delivered approx beats with err_mag!=0;
//                       increments on out_valid&&out_ready; cleared by rst
//     exact product computed in parallel in S2/S3, no latency change.
//   Not defined: ports absent, no exact shadow datapath; core behaviour identical.
// TESTING (W=16, LL_TRUNC=2, TAG_W=4 unless stated)
//   1 A=0xFFFF,B=0xFFFF,mode=1,tag=0x3 -> out_r=0xFFFE0001, tag 0x3, exactly 3 cycles after accept
//   2 A=0xFFFF,B=0xFFFF,mode=0 -> out_r=0xFEFDFA10; with CDM_ERR_MON_EN err_mag=0x010005F1, err_count=1
//   3 A=3,B=5,mode=0 -> out_r=0 (LL truncated); mode=1 -> 15; LL_TRUNC=0 build, mode=0 -> 15
//   4 stream 10 random beats, out_ready low cycles 4-8 -> in_ready falls after 3 in flight,
//     all 10 results in order, match golden model for each mode
//   5 accept 2 beats, assert rst 1 cycle mid-flight -> out_valid stays 0, err_count=0, in_ready=1 next cycle
//   6 random 10k beats, random in_valid/out_ready, random mode -> scoreboard vs merge equations, 0 mismatches

Source files
------------

// File: rtl/cdm_mul_if.sv
// Valid/ready operand and result stream for cdm_mul_pipe.
// master = producer/consumer side (testbench), slave = multiplier side.
interface cdm_mul_if #(
  parameter int W     = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_r;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_r, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_r, out_tag
  );
endinterface

// File: rtl/cdm_mul_pipe.sv
// Three-stage carry-disregard approximate / exact W x W multiplier with valid/ready flow.
// Optional error monitor (err_mag, err_count) enabled by defining CDM_ERR_MON_EN.
module cdm_mul_pipe #(
  parameter int W        = 16,
  parameter int LL_TRUNC = 2,
  parameter int TAG_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  cdm_mul_if.slave   bus
`ifdef CDM_ERR_MON_EN
  ,
  output logic [2*W-1:0] err_mag,
  output logic [15:0]    err_count
`endif
);
  localparam int H = W / 2;
  localparam logic [H-1:0] LL_MASK = {H{1'b1}} << LL_TRUNC;

  function automatic logic [2*H-1:0] widen(input logic [H-1:0] x);
    return {{H{1'b0}}, x};
  endfunction

  // Exact recombination of the four quadrant products.
  function automatic logic [2*W-1:0] full_merge(input logic [2*H-1:0] ll, hl, lh, hh);
    return {hh, ll} + {{H{1'b0}}, hl, {H{1'b0}}} + {{H{1'b0}}, lh, {H{1'b0}}};
  endfunction

  // ---------------- handshake chain ----------------
  logic s1_valid, s2_valid, s3_valid;
  logic ready_1, ready_2, ready_3;

  assign ready_3      = !s3_valid || bus.out_ready;
  assign ready_2      = !s2_valid || ready_3;
  assign ready_1      = !s1_valid || ready_2;
  assign bus.in_ready = ready_1;

  // ---------------- S1: operands ----------------
  logic [W-1:0]     s1_a, s1_b;
  logic             s1_mode;
  logic [TAG_W-1:0] s1_tag;

  // NOTE: all registered state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= 1'b0;
      s1_tag   <= '0;
    end else if (ready_1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a    <= bus.in_a;
        s1_b    <= bus.in_b;
        s1_mode <= bus.in_mode;
        s1_tag  <= bus.in_tag;
      end
    end
  end

  // ---------------- S1 -> S2: quadrant products ----------------
  logic [H-1:0]   a_lo, a_hi, b_lo, b_hi, ll_a, ll_b;
  logic [2*H-1:0] q_ll, q_hl, q_lh, q_hh;

  // NOTE: every output of this block is assigned on every path, so no latch is inferred.
  always_comb begin
    a_lo = s1_a[H-1:0];
    a_hi = s1_a[W-1:H];
    b_lo = s1_b[H-1:0];
    b_hi = s1_b[W-1:H];
    ll_a = s1_mode ? a_lo : (a_lo & LL_MASK);
    ll_b = s1_mode ? b_lo : (b_lo & LL_MASK);
    q_ll = widen(ll_a) * widen(ll_b);
    q_hl = widen(a_hi) * widen(b_lo);
    q_lh = widen(a_lo) * widen(b_hi);
    q_hh = widen(a_hi) * widen(b_hi);
  end

  logic [2*H-1:0]   s2_ll, s2_hl, s2_lh, s2_hh;
  logic             s2_mode;
  logic [TAG_W-1:0] s2_tag;
`ifdef CDM_ERR_MON_EN
  logic [2*H-1:0]   s2_ll_x;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_ll    <= '0;
      s2_hl    <= '0;
      s2_lh    <= '0;
      s2_hh    <= '0;
      s2_mode  <= 1'b0;
      s2_tag   <= '0;
`ifdef CDM_ERR_MON_EN
      s2_ll_x  <= '0;
`endif
    end else if (ready_2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ll   <= q_ll;
        s2_hl   <= q_hl;
        s2_lh   <= q_lh;
        s2_hh   <= q_hh;
        s2_mode <= s1_mode;
        s2_tag  <= s1_tag;
`ifdef CDM_ERR_MON_EN
        s2_ll_x <= widen(a_lo) * widen(b_lo);
`endif
      end
    end
  end

  // ---------------- S2 -> S3: segment merge ----------------
  logic [H-1:0]   seg_mid, seg_hi;
  logic [2*W-1:0] approx_r, merged;

  // Segment sums are H bits wide, so carries between segments fall off by construction.
  always_comb begin
    seg_mid  = s2_ll[2*H-1:H] + s2_hl[H-1:0] + s2_lh[H-1:0];
    seg_hi   = s2_hl[2*H-1:H] + s2_lh[2*H-1:H] + s2_hh[H-1:0];
    approx_r = {s2_hh[2*H-1:H], seg_hi, seg_mid, s2_ll[H-1:0]};
    merged   = s2_mode ? full_merge(s2_ll, s2_hl, s2_lh, s2_hh) : approx_r;
  end

`ifdef CDM_ERR_MON_EN
  logic [2*W-1:0] shadow_r, err_d;

  always_comb begin
    shadow_r = full_merge(s2_ll_x, s2_hl, s2_lh, s2_hh);
    err_d    = (shadow_r >= merged) ? (shadow_r - merged) : (merged - shadow_r);
  end
`endif

  logic [2*W-1:0]   s3_r;
  logic [TAG_W-1:0] s3_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_r     <= '0;
      s3_tag   <= '0;
`ifdef CDM_ERR_MON_EN
      err_mag  <= '0;
`endif
    end else if (ready_3) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_r    <= merged;
        s3_tag  <= s2_tag;
`ifdef CDM_ERR_MON_EN
        err_mag <= err_d;
`endif
      end
    end
  end

  assign bus.out_valid = s3_valid;
  assign bus.out_r     = s3_r;
  assign bus.out_tag   = s3_tag;

`ifdef CDM_ERR_MON_EN
  // Counts delivered beats that carried any error; exact-mode beats always carry zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (s3_valid && bus.out_ready && (err_mag != '0) && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdm_mul_pipe.sv
// Self-checking bench for cdm_mul_pipe: directed corner beats, stall/reset scenarios and
// a long randomized stream against an arithmetic reference model.
module tb_cdm_mul_pipe;
  localparam int W     = 16;
  localparam int TAG_W = 4;
  localparam int LLT   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdm_mul_if #(.W(W), .TAG_W(TAG_W)) bus  ();
  cdm_mul_if #(.W(W), .TAG_W(TAG_W)) bus0 ();

`ifdef CDM_ERR_MON_EN
  logic [2*W-1:0] err_mag, err_mag0;
  logic [15:0]    err_count, err_count0;
`endif

  cdm_mul_pipe #(.W(W), .LL_TRUNC(LLT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef CDM_ERR_MON_EN
    , .err_mag(err_mag), .err_count(err_count)
`endif
  );

  // Second instance with no LL truncation.
  cdm_mul_pipe #(.W(W), .LL_TRUNC(0), .TAG_W(TAG_W)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
`ifdef CDM_ERR_MON_EN
    , .err_mag(err_mag0), .err_count(err_count0)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_err_cnt = 0;

  typedef struct packed {
    logic [2*W-1:0]   r;
    logic [TAG_W-1:0] tag;
    logic [2*W-1:0]   err;
  } exp_t;

  // ---------------- reference model (plain arithmetic on byte quadrants) ----------------
  function automatic logic [31:0] ref_approx(input logic [15:0] a, input logic [15:0] b, input int t);
    longint unsigned alo = a % 256, ahi = a / 256, blo = b % 256, bhi = b / 256;
    longint unsigned m = 64'd1 << t;
    longint unsigned ll = ((alo / m) * m) * ((blo / m) * m);
    longint unsigned hl = ahi * blo, lh = alo * bhi, hh = ahi * bhi;
    longint unsigned s0 = ll % 256;
    longint unsigned s1 = (ll / 256 + hl % 256 + lh % 256) % 256;
    longint unsigned s2 = (hl / 256 + lh / 256 + hh % 256) % 256;
    longint unsigned s3 = hh / 256;
    return 32'(s3 * 64'h100_0000 + s2 * 64'h1_0000 + s1 * 64'h100 + s0);
  endfunction

  function automatic logic [31:0] ref_exact(input logic [15:0] a, input logic [15:0] b);
    return {16'h0, a} * {16'h0, b};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic idle_inputs();
    bus.in_valid  = 1'b0;  bus0.in_valid  = 1'b0;
    bus.in_a      = 16'($urandom); bus.in_b = 16'($urandom);
    bus0.in_a     = 16'($urandom); bus0.in_b = 16'($urandom);
    bus.in_mode   = 1'($urandom);  bus0.in_mode = 1'($urandom);
    bus.in_tag    = 4'($urandom);  bus0.in_tag  = 4'($urandom);
    bus.out_ready = 1'b1;  bus0.out_ready = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_err_cnt = 0;
  endtask

  // Sends one beat into both instances from idle; returns at the negedge where out_valid is seen.
  task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic m,
                          input logic [3:0] t, output logic [31:0] r, output logic [3:0] tg,
                          output logic [31:0] r0, output bit got);
    @(negedge clk);
    bus.in_valid = 1'b1;  bus.in_a = a;  bus.in_b = b;  bus.in_mode = m;  bus.in_tag = t;
    bus0.in_valid = 1'b1; bus0.in_a = a; bus0.in_b = b; bus0.in_mode = m; bus0.in_tag = t;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    got = 1'b0;
    r = '0; tg = '0; r0 = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (bus.out_valid === 1'b1) begin
        got = 1'b1; r = bus.out_r; tg = bus.out_tag; r0 = bus0.out_r;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.out_r !== 32'h0) begin n_err++; $display("FAIL reset_out_r: got %h want 0", bus.out_r); end
    n_vec++; if (bus.out_tag !== 4'h0) begin n_err++; $display("FAIL reset_out_tag: got %h want 0", bus.out_tag); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
`ifdef CDM_ERR_MON_EN
    n_vec++; if (err_count !== 16'h0) begin n_err++; $display("FAIL reset_err_count: got %h want 0", err_count); end
`endif
    exp_err_cnt = 0;
  endtask

  // Exact 0xFFFF^2; out_valid must appear in the third cycle after the accept cycle.
  task automatic test_latency_exact();
    apply_reset();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = 16'hFFFF; bus.in_b = 16'hFFFF; bus.in_mode = 1'b1; bus.in_tag = 4'h3;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL lat_in_ready: got %b want 1", bus.in_ready); end
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      n_vec++;
      if (bus.out_valid !== (k == 3)) begin
        n_err++; $display("FAIL lat_out_valid_c%0d: got %b want %b", k, bus.out_valid, (k == 3));
      end
    end
    n_vec++; if (bus.out_r !== 32'hFFFE0001) begin n_err++; $display("FAIL lat_out_r: got %h want fffe0001", bus.out_r); end
    n_vec++; if (bus.out_tag !== 4'h3) begin n_err++; $display("FAIL lat_out_tag: got %h want 3", bus.out_tag); end
`ifdef CDM_ERR_MON_EN
    n_vec++; if (err_mag !== 32'h0) begin n_err++; $display("FAIL lat_err_mag: got %h want 0", err_mag); end
`endif
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL lat_no_dup: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_approx_ffff();
    logic [31:0] r, r0; logic [3:0] tg; bit got;
    apply_reset();
    send_one(16'hFFFF, 16'hFFFF, 1'b0, 4'hA, r, tg, r0, got);
    n_vec++; if (!got) begin n_err++; $display("FAIL ffff_timeout: got no result want one"); end
    n_vec++; if (r !== 32'hFEFDFA10) begin n_err++; $display("FAIL ffff_approx: got %h want fefdfa10", r); end
    n_vec++; if (tg !== 4'hA) begin n_err++; $display("FAIL ffff_tag: got %h want a", tg); end
    n_vec++; if (r0 !== ref_approx(16'hFFFF, 16'hFFFF, 0)) begin n_err++; $display("FAIL ffff_trunc0: got %h want %h", r0, ref_approx(16'hFFFF, 16'hFFFF, 0)); end
`ifdef CDM_ERR_MON_EN
    n_vec++; if (err_mag !== 32'h010005F1) begin n_err++; $display("FAIL ffff_err_mag: got %h want 010005f1", err_mag); end
    @(negedge clk);
    n_vec++; if (err_count !== 16'd1) begin n_err++; $display("FAIL ffff_err_count: got %0d want 1", err_count); end
`endif
  endtask

  task automatic test_small_operands();
    logic [31:0] r, r0; logic [3:0] tg; bit got;
    apply_reset();
    send_one(16'd3, 16'd5, 1'b0, 4'h1, r, tg, r0, got);
    n_vec++; if (!got || r !== 32'd0) begin n_err++; $display("FAIL small_approx: got %h (valid %b) want 0", r, got); end
    n_vec++; if (!got || r0 !== 32'd15) begin n_err++; $display("FAIL small_trunc0: got %h (valid %b) want f", r0, got); end
    send_one(16'd3, 16'd5, 1'b1, 4'h2, r, tg, r0, got);
    n_vec++; if (!got || r !== 32'd15) begin n_err++; $display("FAIL small_exact: got %h (valid %b) want f", r, got); end
    n_vec++; if (tg !== 4'h2) begin n_err++; $display("FAIL small_tag: got %h want 2", tg); end
  endtask

  // Streams n random beats; out_ready forced low in cycles [stall_lo, stall_hi].
  task automatic test_stream(input string name, input int n, input int vp, input int rp,
                             input int stall_lo, input int stall_hi, input bit need_bp);
    exp_t q[$];
    exp_t e;
    int sent = 0, got = 0, cyc = 0, max_fly = 0;
    bit saw_bp = 1'b0, hold = 1'b0;
    logic [31:0] hold_r;
    logic [3:0]  hold_tag;
    logic [15:0] a, b;
    apply_reset();
    while (got < n && cyc < n * 20 + 100) begin
      @(negedge clk);
      idle_inputs();
      if (sent < n && int'($urandom_range(99)) < vp) bus.in_valid = 1'b1;
      bus.out_ready = (cyc >= stall_lo && cyc <= stall_hi) ? 1'b0 : (int'($urandom_range(99)) < rp);
      #1;
      n_vec++;
      if (bus.in_ready !== ((q.size() < 3) || bus.out_ready)) begin
        n_err++; $display("FAIL %s_in_ready c%0d: got %b want %b (in flight %0d)", name, cyc, bus.in_ready, (q.size() < 3) || bus.out_ready, q.size());
      end
      if (hold) begin
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_r !== hold_r || bus.out_tag !== hold_tag) begin
          n_err++; $display("FAIL %s_hold c%0d: got v=%b r=%h t=%h want v=1 r=%h t=%h", name, cyc, bus.out_valid, bus.out_r, bus.out_tag, hold_r, hold_tag);
        end
      end
      if (bus.in_valid && !bus.in_ready && q.size() == 3) saw_bp = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL %s_spurious c%0d: got r=%h want no result", name, cyc, bus.out_r);
        end else begin
          e = q.pop_front();
          if (bus.out_r !== e.r || bus.out_tag !== e.tag) begin
            n_err++; $display("FAIL %s_result #%0d: got r=%h t=%h want r=%h t=%h", name, got, bus.out_r, bus.out_tag, e.r, e.tag);
          end
`ifdef CDM_ERR_MON_EN
          n_vec++;
          if (err_mag !== e.err) begin
            n_err++; $display("FAIL %s_err_mag #%0d: got %h want %h", name, got, err_mag, e.err);
          end
`endif
          if (e.err != 0) exp_err_cnt++;
        end
        got++;
      end
      hold = bus.out_valid && !bus.out_ready;
      hold_r = bus.out_r;
      hold_tag = bus.out_tag;
      if (bus.in_valid && bus.in_ready) begin
        a = bus.in_a; b = bus.in_b;
        e.r   = bus.in_mode ? ref_exact(a, b) : ref_approx(a, b, LLT);
        e.tag = bus.in_tag;
        e.err = ref_exact(a, b) - e.r;
        q.push_back(e);
        sent++;
      end
      if (q.size() > max_fly) max_fly = q.size();
      cyc++;
    end
    @(negedge clk);
    idle_inputs();
    n_vec++; if (got != n) begin n_err++; $display("FAIL %s_count: got %0d results want %0d", name, got, n); end
    n_vec++; if (max_fly > 3) begin n_err++; $display("FAIL %s_in_flight: got %0d want <=3", name, max_fly); end
    if (need_bp) begin
      n_vec++; if (!saw_bp) begin n_err++; $display("FAIL %s_backpressure: got none want in_ready low at 3 in flight", name); end
    end
`ifdef CDM_ERR_MON_EN
    n_vec++;
    if (err_count !== 16'((exp_err_cnt > 65535) ? 65535 : exp_err_cnt)) begin
      n_err++; $display("FAIL %s_err_count: got %0d want %0d", name, err_count, exp_err_cnt);
    end
`endif
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_a = 16'hFFFF; bus.in_b = 16'h00FF - 16'(i); bus.in_mode = 1'b0; bus.in_tag = 4'(i);
      @(posedge clk);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); end
    for (int k = 0; k < 6; k++) begin
      n_vec++;
      if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid c%0d: got %b want 0", k, bus.out_valid); end
      @(negedge clk);
      #1;
    end
`ifdef CDM_ERR_MON_EN
    n_vec++; if (err_count !== 16'h0) begin n_err++; $display("FAIL rstmid_err_count: got %0d want 0", err_count); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_latency_exact();
    test_approx_ffff();
    test_small_operands();
    test_stream("stall", 10, 100, 100, 4, 8, 1'b1);
    test_reset_midflight();
    test_stream("random", 10000, 70, 70, -1, -2, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
